// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg: shared diagnostic-state type for the FWFT level FIFO.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int DIAG_W = 2;

  typedef enum logic [DIAG_W-1:0] {
    DIAG_EMPTY   = 2'd0,
    DIAG_PARTIAL = 2'd1,
    DIAG_FULL    = 2'd2
  } diag_state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_ptr.sv
// ----------------------------------------------------------------------------
// fifo_ptr: wrapping address counter, 0..DEPTH-1, any DEPTH >= 2.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  advance_i,
  input  logic                  clear_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // Explicit compare against DEPTH-1 so non-power-of-two depths wrap correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (advance_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fifo_fwft_level.sv
// ----------------------------------------------------------------------------
// fifo_fwft_level: first-word-fall-through FIFO with level/sticky-error flags.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_fwft_level
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Flush,
  input  logic                  i_Data_Valid,
  input  logic [DATA_WIDTH-1:0] i_Data,
  output logic                  o_Full,
  input  logic                  i_Read,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Empty,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Almost_Full,
  output logic                  o_Almost_Empty,
  output logic                  o_Overflow,
  output logic                  o_Underflow,
  input  logic                  i_Clear_Err,
  output logic [DIAG_W-1:0]     o_Diag_State,
  output logic [ADDR_WIDTH-1:0] o_Diag_Buf_W_Addr,
  output logic [ADDR_WIDTH-1:0] o_Diag_Buf_R_Addr
);

  localparam int               CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_THR  = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_THR  = CNT_W'(AE_LEVEL);
  localparam logic             AF_RST  = (AF_LEVEL <= 0);
  localparam logic             AE_RST  = (AE_LEVEL >= 0);

  logic                  wr_en;
  logic                  rd_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q,  full_d;
  logic                  af_q,    af_d;
  logic                  ae_q,    ae_d;
  logic                  ovf_q,   ovf_d;
  logic                  unf_q,   unf_d;
  diag_state_e           state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // A write into a full FIFO is legal when the same edge pops a word.
  assign wr_en  = i_Data_Valid & (~full_q | i_Read) & ~i_Flush;
  assign rd_en  = i_Read & ~empty_q & ~i_Flush;
  assign mem_we = wr_en & i_Rst_n;

  fifo_ptr #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk_i     (i_Clk),
    .rst_ni    (i_Rst_n),
    .advance_i (wr_en),
    .clear_i   (i_Flush),
    .ptr_o     (wr_ptr)
  );

  fifo_ptr #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk_i     (i_Clk),
    .rst_ni    (i_Rst_n),
    .advance_i (rd_en),
    .clear_i   (i_Flush),
    .ptr_o     (rd_ptr)
  );

  always_ff @(posedge i_Clk) begin
    if (mem_we) begin
      mem_q[wr_ptr] <= i_Data;
    end
  end

  always_comb begin
    count_d = count_q;
    if (i_Flush) begin
      count_d = '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_MAX);
    af_d    = (count_d >= AF_THR);
    ae_d    = (count_d <= AE_THR);
  end

  // Clear wins over a same-cycle error; flushed requests raise no error.
  always_comb begin
    ovf_d = ovf_q | (~i_Flush & i_Data_Valid & full_q & ~i_Read);
    unf_d = unf_q | (~i_Flush & i_Read & empty_q);
    if (i_Clear_Err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIAG_EMPTY: begin
        if (!empty_d) state_d = DIAG_PARTIAL;
      end
      DIAG_PARTIAL: begin
        if (empty_d)     state_d = DIAG_EMPTY;
        else if (full_d) state_d = DIAG_FULL;
      end
      DIAG_FULL: begin
        if (empty_d)     state_d = DIAG_EMPTY;
        else if (!full_d) state_d = DIAG_PARTIAL;
      end
      default: state_d = DIAG_EMPTY;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= AF_RST;
      ae_q    <= AE_RST;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= DIAG_EMPTY;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      state_q <= state_d;
    end
  end

  assign o_Data            = mem_q[rd_ptr];
  assign o_Empty           = empty_q;
  assign o_Full            = full_q;
  assign o_Count           = count_q;
  assign o_Almost_Full     = af_q;
  assign o_Almost_Empty    = ae_q;
  assign o_Overflow        = ovf_q;
  assign o_Underflow       = unf_q;
  assign o_Diag_State      = state_q;
  assign o_Diag_Buf_W_Addr = wr_ptr;
  assign o_Diag_Buf_R_Addr = rd_ptr;

endmodule

`default_nettype wire
